spi_mstr_cfg: RTL and testbench
===============================

// Module: spi_mstr_cfg
// PURPOSE
//  Parametrised SPI master, successor to the fixed 16-bit mode-3 master used by the sensor/IMU interfaces.
//  Adds configurable frame width, SCLK divider, per-transfer SPI mode (CPOL/CPHA) and multiple slave selects.
//  A single wrt pulse runs one full-duplex frame. done is sticky and rd_data holds the MISO frame.
//  Sits between the sensor-polling FSMs and the board SPI pins.
// PARAMETERS
//  DATA_W      16  bits per frame (4..32)
//  SCLK_DIV_W  6   SCLK period = 2**SCLK_DIV_W clk; H = 2**(SCLK_DIV_W-1) clk per SCLK half-period (>=2)
//  NUM_SS      1   number of active-low slave selects (1..8)
// PORTS
//  clk      in   1                  system clock
//  rst_n    in   1                  asynchronous active-low reset
//  wrt      in   1                  start request; sampled only in IDLE
//  cmd      in   DATA_W             frame to transmit; latched on accepted wrt
//  mode     in   2                  {CPOL,CPHA}; latched on accepted wrt
//  ss_sel   in   max(1,$clog2(NUM_SS))  slave index; latched on accepted wrt; values >= NUM_SS select none
//  SS_n     out  NUM_SS             active-low slave selects
//  SCLK     out  1                  serial clock
//  MOSI     out  1                  serial data out
//  MISO     in   1                  serial data in
//  busy     out  1                  high from cycle after accepted wrt until done rises
//  done     out  1                  sticky completion flag; cleared by next accepted wrt
//  rd_data  out  DATA_W             received frame; updated once, in the cycle done rises
// BEHAVIOUR
//  Reset: SS_n all 1, SCLK=0, MOSI=0, busy=0, done=0, rd_data=0, state IDLE. Latched mode resets to 2'b00.
//  Reset mid-frame aborts immediately. No partial rd_data; done stays 0.
//  FSM IDLE->FRONT->XFER->BACK->IDLE.
//   IDLE: SCLK=CPOL (latched). wrt=1 accepts: latch cmd/mode/ss_sel, done<=0, go FRONT.
//   wrt while busy is ignored; there is no queueing.
//  Edge numbering: accepted wrt at cycle 0. SS_n[ss_sel] falls at cycle 1.
//   SCLK edge k (k=1..2*DATA_W) toggles at cycle 1+k*H.
//   Odd k = leading edge; even k = trailing edge.
//  CPHA=0: MOSI = frame MSB from cycle 1. Sample MISO on leading edges.
//   Shift MOSI on trailing edges 2..2*DATA_W-2.
//  CPHA=1: MOSI shifts on leading edges 3..2*DATA_W-1; MSB is presented from cycle 1.
//   Sample MISO on trailing edges.
//  Sampling: rx shift reg <= {rx[DATA_W-2:0],MISO} in the clk that the sample edge is generated.
//  BACK: after edge 2*DATA_W, hold SCLK=CPOL for H clk.
//   At cycle 1+H*(2*DATA_W+1): SS_n all 1, done<=1, busy<=0, rd_data<=rx, IDLE.
//  Frame latency, wrt to done: 1+H*(2*DATA_W+1). Defaults: 1057 clk.
//  Back-to-back: wrt in the cycle done rises is accepted; the next SS_n low is >=1 clk after the rise.
//  Counters: edge counter is $clog2(2*DATA_W+1) bits and never wraps mid-frame.
//   The divider restarts from 0 on every accepted wrt.
// CONFIGURATION
//  SPI_MSTR_LSB_FIRST_EN defined: adds input lsb_first (1 bit), latched on accepted wrt.
//   When 1, TX shifts out bit 0 first and RX fills from the MSB end (rx <= {MISO,rx[DATA_W-1:1]}).
//  Undefined: port absent; MSB-first only.
// STRUCTURE
//  Package spi_pkg: typedef enum logic[1:0] {IDLE,FRONT,XFER,BACK} spi_state_t;
//   typedef struct packed {logic cpol; logic cpha;} spi_mode_t; localparam SPI_MODE3 = 2'b11.
//  Sub-module spi_sclk_gen: divider counter plus single-cycle lead_pls/trail_pls, with a restart input.
//   The top level holds the FSM, edge counter, TX/RX shift registers and latched config.
// TESTING
//  1 mode=3, cmd=16'hA5C3, MOSI looped to MISO -> done at cycle 1057; rd_data=16'hA5C3; SCLK idles high.
//  2 mode=0, slave model returns 16'h1234 -> rd_data=16'h1234; SCLK idles low; 16 rising edges inside SS_n low.
//  3 wrt re-pulsed at cycle 200 with cmd=16'hFFFF -> ignored; frame still 16'hA5C3; one done rise.
//  4 NUM_SS=4, ss_sel=2 -> only SS_n[2] low (SS_n=4'b1011); ss_sel=5 -> SS_n=4'b1111 and frame still runs.
//  5 rst_n low at cycle 400 -> SS_n all 1, SCLK=0, busy=0, done=0, rd_data=0; fresh wrt completes normally.
//  6 DATA_W=8, SCLK_DIV_W=2, SPI_MSTR_LSB_FIRST_EN, lsb_first=1, cmd=8'h01, loopback
//    -> MOSI high on first bit; rd_data=8'h01; done at cycle 35.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM states, the latched SPI mode
// and the mode-3 constant used by the sensor interfaces.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRONT,
    XFER,
    BACK
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timebase: down-counter reloading every 2**(DIV_W-1) clk, emitting one-cycle
// pulses that alternate leading/trailing, starting with leading after restart.
module spi_sclk_gen #(
  parameter int DIV_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic lead_pls,
  output logic trail_pls
);

  localparam int CNT_W = DIV_W - 1;

  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             tc;

  assign tc        = en && (cnt == '0);
  assign lead_pls  = tc && !phase;
  assign trail_pls = tc && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '1;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '1;
      phase <= 1'b0;
    end else if (tc) begin
      cnt   <= '1;
      phase <= ~phase;
    end else if (en) begin
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_mstr_cfg.sv
// Parametrised full-duplex SPI master: frame width, SCLK divider, per-transfer mode and slave select.
// Optional build macro SPI_MSTR_LSB_FIRST_EN adds a latched lsb_first input.
//
// state | meaning
// IDLE  | SCLK parked at CPOL, SS_n all high, waiting for wrt
// FRONT | SS_n low, waiting for the first SCLK edge
// XFER  | SCLK edges 1..2*DATA_W, shifting TX and sampling RX
// BACK  | SCLK parked at CPOL for one half-period before SS_n release
module spi_mstr_cfg
  import spi_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int SCLK_DIV_W = 6,
  parameter  int NUM_SS     = 1,
  localparam int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [1:0]        mode,
  input  logic [SS_W-1:0]   ss_sel,
`ifdef SPI_MSTR_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int              EC_W      = $clog2(2 * DATA_W + 1);
  localparam logic [EC_W-1:0] LAST_XFER = EC_W'(2 * DATA_W - 1);

  spi_state_t        state, state_nxt;
  spi_mode_t         mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [EC_W-1:0]   edge_cnt;
  logic              lead_pls, trail_pls;
  logic              accept, edge_stb, finish, shift_tx, sample_rx;
  logic [NUM_SS-1:0] ss_dec;

  spi_sclk_gen #(
    .DIV_W(SCLK_DIV_W)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .restart  (accept),
    .lead_pls (lead_pls),
    .trail_pls(trail_pls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    edge_stb  = 1'b0;
    finish    = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    case (state)
      IDLE: begin
        if (wrt) begin
          accept    = 1'b1;
          state_nxt = FRONT;
        end
      end
      FRONT: begin
        if (lead_pls) begin
          edge_stb  = 1'b1;
          sample_rx = !mode_q.cpha;
          state_nxt = XFER;
        end
      end
      XFER: begin
        edge_stb = lead_pls || trail_pls;
        // Edge 1 lives in FRONT, so every leading edge seen here is 3..2*DATA_W-1.
        if (mode_q.cpha) begin
          shift_tx  = lead_pls;
          sample_rx = trail_pls;
        end else begin
          shift_tx  = trail_pls && (edge_cnt != LAST_XFER);
          sample_rx = lead_pls;
        end
        if (trail_pls && (edge_cnt == LAST_XFER)) state_nxt = BACK;
      end
      BACK: begin
        if (lead_pls) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range ss_sel leaves every select high; the frame still runs.
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) ss_dec[i] = (int'(ss_sel) != i);
  end

`ifdef SPI_MSTR_LSB_FIRST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lsb_q <= 1'b0;
    else if (accept) lsb_q <= lsb_first;
  end
`else
  assign lsb_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      edge_cnt <= '0;
      SS_n     <= '1;
      SCLK     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (accept) begin
        mode_q   <= spi_mode_t'(mode);
        tx_q     <= cmd;
        rx_q     <= '0;
        edge_cnt <= '0;
        SS_n     <= ss_dec;
        SCLK     <= mode[1];
        busy     <= 1'b1;
        done     <= 1'b0;
      end
      if (edge_stb) begin
        SCLK     <= ~SCLK;
        edge_cnt <= edge_cnt + EC_W'(1);
      end
      if (shift_tx)
        tx_q <= lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
      if (sample_rx)
        rx_q <= lsb_q ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
      if (finish) begin
        SS_n    <= '1;
        SCLK    <= mode_q.cpol;
        busy    <= 1'b0;
        done    <= 1'b1;
        rd_data <= rx_q;
      end
    end
  end

  assign MOSI = lsb_q ? tx_q[0] : tx_q[DATA_W-1];

endmodule

// File: tb/tb_spi_mstr_cfg.sv
// Directed bench for spi_mstr_cfg: a 16-bit/5-slave instance and an 8-bit fast-divider instance.
// Honours SPI_MSTR_LSB_FIRST_EN when the build defines it.
module tb_spi_mstr_cfg;
  import spi_pkg::*;

  localparam int NSS0 = 5;

  int n_chk = 0;
  int n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic            wrt0, loop0;
  logic [15:0]     cmd0, rd0;
  logic [1:0]      mode0;
  logic [2:0]      sel0;
  logic [NSS0-1:0] ss0;
  logic            sclk0, mosi0, miso0, busy0, done0;

  logic            wrt1, lsb1;
  logic [7:0]      cmd1, rd1;
  logic [1:0]      mode1;
  logic [0:0]      sel1, ss1;
  logic            sclk1, mosi1, busy1, done1;

  logic [15:0] slv;
  logic        sclk_prev, ss_prev;
  int          rise_cnt = 0;

  assign miso0 = loop0 ? mosi0 : slv[15];

  spi_mstr_cfg #(.DATA_W(16), .SCLK_DIV_W(6), .NUM_SS(NSS0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt0), .cmd(cmd0), .mode(mode0), .ss_sel(sel0),
    .SS_n(ss0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0),
    .busy(busy0), .done(done0), .rd_data(rd0)
  );

  spi_mstr_cfg #(.DATA_W(8), .SCLK_DIV_W(2), .NUM_SS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt1), .cmd(cmd1), .mode(mode1), .ss_sel(sel1),
`ifdef SPI_MSTR_LSB_FIRST_EN
    .lsb_first(lsb1),
`endif
    .SS_n(ss1), .SCLK(sclk1), .MOSI(mosi1), .MISO(mosi1),
    .busy(busy1), .done(done1), .rd_data(rd1)
  );

  // Mode-0 slave on SS_n[0]: preloads 16'h1234, shifts on SCLK falling edges.
  always @(posedge clk) begin
    if (ss0[0]) slv <= 16'h1234;
    else if (!ss_prev && sclk_prev && !sclk0) slv <= {slv[14:0], 1'b0};
    if (!ss0[0] && !ss_prev && !sclk_prev && sclk0) rise_cnt <= rise_cnt + 1;
    sclk_prev <= sclk0;
    ss_prev   <= ss0[0];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Runs one dut0 frame; latency counted in clk from the wrt cycle to done high.
  task automatic run0(input logic [15:0] c, input logic [1:0] m, input logic [2:0] s,
                      input bit lp, input bit repulse,
                      output int lat, output int rises,
                      output logic [NSS0-1:0] ss_at1, output logic busy_at1);
    logic dprev;
    int   n;
    @(negedge clk);
    loop0 = lp; cmd0 = c; mode0 = m; sel0 = s; wrt0 = 1'b1;
    lat = -1; rises = 0; dprev = 1'b0; ss_at1 = '0; busy_at1 = 1'b0;
    n = 1;
    @(negedge clk);
    while (n <= 3000) begin
      if (repulse && n == 200) begin
        cmd0 = 16'hFFFF; wrt0 = 1'b1;
      end else begin
        wrt0 = 1'b0;
      end
      if (n == 1) begin
        ss_at1 = ss0; busy_at1 = busy0;
      end
      if (done0 && !dprev) begin
        rises++;
        if (lat < 0) lat = n;
      end
      dprev = done0;
      if (lat >= 0 && n >= lat + 20) break;
      n++;
      @(negedge clk);
    end
    wrt0 = 1'b0;
  endtask

  task automatic run1(input logic [7:0] c, input logic [1:0] m, input logic lsb,
                      output int lat, output logic mosi_at1);
    int n;
    @(negedge clk);
    cmd1 = c; mode1 = m; lsb1 = lsb; wrt1 = 1'b1;
    lat = -1; mosi_at1 = 1'b0;
    n = 1;
    @(negedge clk);
    wrt1 = 1'b0;
    while (n <= 200 && lat < 0) begin
      if (n == 1) mosi_at1 = mosi1;
      if (done1) lat = n;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, rises, r0;
    logic [NSS0-1:0] ss_at1;
    logic busy_at1, mosi_at1;

    rst_n = 1'b0;
    wrt0 = 1'b0; loop0 = 1'b1; cmd0 = '0; mode0 = '0; sel0 = '0;
    wrt1 = 1'b0; lsb1 = 1'b0; cmd1 = '0; mode1 = '0; sel1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n",  32'(ss0),   32'h1F);
    chk("rst_sclk",  32'(sclk0), 32'h0);
    chk("rst_mosi",  32'(mosi0), 32'h0);
    chk("rst_busy",  32'(busy0), 32'h0);
    chk("rst_done",  32'(done0), 32'h0);
    chk("rst_rdata", 32'(rd0),   32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 3 loopback, with an ignored wrt at cycle 200
    run0(16'hA5C3, SPI_MODE3, 3'd0, 1'b1, 1'b1, lat, rises, ss_at1, busy_at1);
    chk("m3_latency",  32'(lat),      32'd1057);
    chk("m3_rdata",    32'(rd0),      32'hA5C3);
    chk("m3_one_done", 32'(rises),    32'd1);
    chk("m3_sclk_idle",32'(sclk0),    32'h1);
    chk("m3_ss_at1",   32'(ss_at1),   32'h1E);
    chk("m3_busy_at1", 32'(busy_at1), 32'h1);
    chk("m3_busy_end", 32'(busy0),    32'h0);
    chk("m3_ss_end",   32'(ss0),      32'h1F);

    // Mode 0 against the slave model
    r0 = rise_cnt;
    run0(16'h0000, 2'b00, 3'd0, 1'b0, 1'b0, lat, rises, ss_at1, busy_at1);
    chk("m0_latency",  32'(lat),            32'd1057);
    chk("m0_rdata",    32'(rd0),            32'h1234);
    chk("m0_sclk_idle",32'(sclk0),          32'h0);
    chk("m0_rises",    32'(rise_cnt - r0),  32'd16);

    // Slave select decode, in range and out of range
    run0(16'h0F0F, 2'b01, 3'd2, 1'b1, 1'b0, lat, rises, ss_at1, busy_at1);
    chk("sel2_ss",    32'(ss_at1), 32'h1B);
    chk("sel2_rdata", 32'(rd0),    32'h0F0F);
    run0(16'h8001, 2'b10, 3'd5, 1'b1, 1'b0, lat, rises, ss_at1, busy_at1);
    chk("sel5_ss",      32'(ss_at1), 32'h1F);
    chk("sel5_latency", 32'(lat),    32'd1057);
    chk("sel5_rdata",   32'(rd0),    32'h8001);
    chk("sel5_sclk",    32'(sclk0),  32'h1);

    // Reset mid-frame
    @(negedge clk);
    loop0 = 1'b1; cmd0 = 16'h3C3C; mode0 = SPI_MODE3; sel0 = 3'd1; wrt0 = 1'b1;
    @(negedge clk);
    wrt0 = 1'b0;
    repeat (399) @(negedge clk);
    chk("abort_busy_pre", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n",  32'(ss0),   32'h1F);
    chk("abort_sclk",  32'(sclk0), 32'h0);
    chk("abort_busy",  32'(busy0), 32'h0);
    chk("abort_done",  32'(done0), 32'h0);
    chk("abort_rdata", 32'(rd0),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run0(16'h5A0F, 2'b00, 3'd1, 1'b1, 1'b0, lat, rises, ss_at1, busy_at1);
    chk("fresh_latency", 32'(lat),    32'd1057);
    chk("fresh_rdata",   32'(rd0),    32'h5A0F);
    chk("fresh_ss_at1",  32'(ss_at1), 32'h1D);

    // 8-bit frame, H=2
`ifdef SPI_MSTR_LSB_FIRST_EN
    run1(8'h01, 2'b00, 1'b1, lat, mosi_at1);
    chk("w8_lsb_mosi1", 32'(mosi_at1), 32'h1);
`else
    run1(8'h01, 2'b00, 1'b0, lat, mosi_at1);
    chk("w8_msb_mosi1", 32'(mosi_at1), 32'h0);
`endif
    chk("w8_latency", 32'(lat), 32'd35);
    chk("w8_rdata",   32'(rd1), 32'h01);
    run1(8'hB4, SPI_MODE3, 1'b0, lat, mosi_at1);
    chk("w8_m3_mosi1",   32'(mosi_at1), 32'h1);
    chk("w8_m3_latency", 32'(lat),      32'd35);
    chk("w8_m3_rdata",   32'(rd1),      32'hB4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
